// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register controller.
// Holds the FSM state encoding, the default word width and the counter sizing helper.
package shift_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a word of 'width' bits; never below one bit.
  function automatic int cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Bit counter for the serializer: synchronous clear, increment, and a terminal-count
// flag raised when the last bit of the word is on the serial output.
module shift_cnt
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      // Wrap at the terminal count so the counter never exceeds WIDTH-1.
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Controller for an external parallel-load/shift-right register: loads a word on START,
// streams it LSB first on SOUT under SOUT_READY flow control, and pulses DONE per word.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] sr_q,
  input  logic             sout_ready,
  output logic [WIDTH-1:0] sr_in,
  output logic             shift_load,
  output logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             ack,
  output logic             busy,
  output logic             done
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_tc;
  logic   unused_sr_bits;

  shift_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .tc (cnt_tc)
  );

  // The serial bit is always the register's LSB; upper bits are the register's own business.
  assign sout           = sr_q[0];
  assign unused_sr_bits = ^sr_q[WIDTH-1:1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= SHIFT;
        SHIFT: begin
          if (abort)                        state <= IDLE;
          else if (sout_ready && cnt_tc)    state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    en         = 1'b0;
    shift_load = 1'b0;
    sr_in      = din;
    ack        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    sout_valid = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (!rst) begin
      sr_in = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ack     = 1'b1;
            en      = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        SHIFT: begin
          busy       = 1'b1;
          sout_valid = 1'b1;
          // Abort wins over flow control and wipes the register.
          if (abort) begin
            en      = 1'b1;
            sr_in   = '0;
            cnt_clr = 1'b1;
          end else if (sout_ready) begin
            en         = 1'b1;
            shift_load = 1'b1;
            cnt_inc    = 1'b1;
          end
        end
        DONE: begin
          done = 1'b1;
          busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
